fft_peak_bcd: RTL and testbench

Streaming peak-bin detector on the FFT output path. It consumes the Re/Im result stream during one frame and computes the squared magnitude from the top 8 bits of each component. It tracks the largest bin and, at frame end, publishes that bin's index as four BCD digits plus a binary index for the seven-segment display front end. It is the producer of the "maximum channel" value that the display block reads.

---
 rtl/fft_peak_bcd_pkg.sv | 41 ++++
 rtl/fft_peak_bcd_bcd_counter4.sv | 32 +++
 rtl/fft_peak_bcd.sv | 219 +++++++++++++++++++++
 tb/tb_fft_peak_bcd.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_peak_bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_peak_bcd_pkg
//  Description : Shared definitions for the FFT peak-bin detector: state
//                encodings, magnitude width and the 4-digit BCD increment.
//  Revision    : 1.0  initial release
// ============================================================================
package fft_peak_bcd_pkg;

    localparam int MAG_W = 17;
    localparam int BCD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Add one to a packed 4-digit BCD value; each digit wraps 9->0 and
    // carries into the next, so 9999 rolls over to 0000.
    function automatic logic [BCD_W-1:0] bcd4_inc(input logic [BCD_W-1:0] i_val);
        logic [BCD_W-1:0] v_res;
        logic             v_carry;
        v_res   = i_val;
        v_carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (v_carry) begin
                if (i_val[d*4 +: 4] == 4'd9) begin
                    v_res[d*4 +: 4] = 4'd0;
                end else begin
                    v_res[d*4 +: 4] = i_val[d*4 +: 4] + 4'd1;
                    v_carry         = 1'b0;
                end
            end
        end
        return v_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_peak_bcd_bcd_counter4.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_counter4
//  Description : Four-digit cascaded BCD counter with synchronous clear and
//                increment enable. Clear has priority over increment.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_counter4
    import fft_peak_bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [BCD_W-1:0] o_count
);

    logic [BCD_W-1:0] r_count;

    // Count register: clear wins, otherwise step by one BCD unit.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= bcd4_inc(r_count);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fft_peak_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : fft_peak_bcd
//  Description : Streaming peak-bin detector. Squares the top 8 bits of each
//                Re/Im sample, tracks the strongest bin of a frame and
//                publishes its index (binary and BCD) at frame end.
//  Revision    : 1.0  initial release
// ============================================================================
module fft_peak_bcd
    import fft_peak_bcd_pkg::*;
#(
    parameter int bit_width = 34,
    parameter int N         = 32,
    parameter int SIZE      = 5
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en_FFT,
    input  logic                        en_comp,
    input  logic signed [bit_width-1:0] Re_in,
    input  logic signed [bit_width-1:0] Im_in,
    input  logic                        done_all,
    output logic [BCD_W-1:0]            peak_bcd,
    output logic [SIZE-1:0]             peak_bin,
    output logic [MAG_W-1:0]            peak_mag,
    output logic                        peak_valid,
    output logic                        busy,
    output logic                        overflow
);

    // Index counter needs one extra bit so it can saturate at N itself.
    localparam logic [SIZE:0] c_N = (SIZE+1)'(N);

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    state_t             r_state;
    logic               r_drain_last;
    logic               r_busy;
    logic               r_peak_valid;
    logic [BCD_W-1:0]   r_peak_bcd;
    logic [SIZE-1:0]    r_peak_bin;
    logic [MAG_W-1:0]   r_peak_mag;

    // Frame (re)start is honoured everywhere except the single DONE cycle.
    logic w_start;
    logic w_accept;
    logic w_in_range;

    assign w_start    = en_FFT && (r_state != ST_DONE);
    assign w_accept   = en_comp && (r_state == ST_ACCUM) && !en_FFT;

    // ------------------------------------------------------------------
    // Input truncation and squaring
    // ------------------------------------------------------------------
    logic signed [7:0]  w_re8;
    logic signed [7:0]  w_im8;
    logic signed [15:0] w_re16;
    logic signed [15:0] w_im16;
    logic signed [15:0] w_re_sq;
    logic signed [15:0] w_im_sq;
    logic               w_unused;

    assign w_re8    = Re_in[bit_width-1 -: 8];
    assign w_im8    = Im_in[bit_width-1 -: 8];
    assign w_re16   = 16'(w_re8);
    assign w_im16   = 16'(w_im8);
    // (-128)^2 = 16384 still fits a signed 16-bit product.
    assign w_re_sq  = w_re16 * w_re16;
    assign w_im_sq  = w_im16 * w_im16;
    assign w_unused = ^{Re_in[bit_width-9:0], Im_in[bit_width-9:0]};

    // ------------------------------------------------------------------
    // Bin index counters
    // ------------------------------------------------------------------
    logic [SIZE:0]      r_idx;
    logic               r_overflow;
    logic [BCD_W-1:0]   w_bcd_idx;

    assign w_in_range = (r_idx < c_N);

    bcd_counter4 u_bcd_idx (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_start),
        .i_inc   (w_accept),
        .o_count (w_bcd_idx)
    );

    // Binary index saturates at N; samples beyond it only raise overflow.
    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_idx      <= '0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            if (w_in_range) begin
                r_idx <= r_idx + 1'b1;
            end else begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: squares plus the index tags of the sample
    // ------------------------------------------------------------------
    logic               r_s1_vld;
    logic               r_s1_first;
    logic [15:0]        r_re_sq;
    logic [15:0]        r_im_sq;
    logic [SIZE-1:0]    r_s1_bin;
    logic [BCD_W-1:0]   r_s1_bcd;

    // Register the squared components; a restart flushes the stage.
    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_s1_vld   <= 1'b0;
            r_s1_first <= 1'b0;
            r_re_sq    <= '0;
            r_im_sq    <= '0;
            r_s1_bin   <= '0;
            r_s1_bcd   <= '0;
        end else begin
            r_s1_vld   <= w_accept && w_in_range;
            r_s1_first <= (r_idx == '0);
            r_re_sq    <= w_re_sq;
            r_im_sq    <= w_im_sq;
            r_s1_bin   <= r_idx[SIZE-1:0];
            r_s1_bcd   <= w_bcd_idx;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: magnitude, compare and candidate update
    // ------------------------------------------------------------------
    logic [MAG_W-1:0]   w_mag;
    logic [MAG_W-1:0]   r_max;
    logic [SIZE-1:0]    r_cand_bin;
    logic [BCD_W-1:0]   r_cand_bcd;

    assign w_mag = {1'b0, r_re_sq} + {1'b0, r_im_sq};

    // Strict greater-than keeps the earliest bin on ties; bin 0 always loads.
    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_max      <= '0;
            r_cand_bin <= '0;
            r_cand_bcd <= '0;
        end else if (r_s1_vld && (r_s1_first || (w_mag > r_max))) begin
            r_max      <= w_mag;
            r_cand_bin <= r_s1_bin;
            r_cand_bcd <= r_s1_bcd;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM with registered status and published outputs
    // ------------------------------------------------------------------
    // DRAIN lasts two cycles so the final sample clears both pipeline stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_drain_last <= 1'b0;
            r_busy       <= 1'b0;
            r_peak_valid <= 1'b0;
            r_peak_bcd   <= '0;
            r_peak_bin   <= '0;
            r_peak_mag   <= '0;
        end else begin
            r_peak_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (en_FFT) begin
                        r_state <= ST_ACCUM;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (en_FFT) begin
                        r_state <= ST_ACCUM;
                    end else if (done_all) begin
                        r_state      <= ST_DRAIN;
                        r_drain_last <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (en_FFT) begin
                        r_state <= ST_ACCUM;
                    end else if (r_drain_last) begin
                        r_state      <= ST_DONE;
                        r_busy       <= 1'b0;
                        r_peak_valid <= 1'b1;
                        r_peak_bcd   <= r_cand_bcd;
                        r_peak_bin   <= r_cand_bin;
                        r_peak_mag   <= r_max;
                    end else begin
                        r_drain_last <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign peak_bcd   = r_peak_bcd;
    assign peak_bin   = r_peak_bin;
    assign peak_mag   = r_peak_mag;
    assign peak_valid = r_peak_valid;
    assign busy       = r_busy;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fft_peak_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_peak_bcd
//  Description : Self-checking bench for fft_peak_bcd with a frame-level
//                reference model and directed frames.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fft_peak_bcd;

    localparam int BW = 34;
    localparam int NB = 32;
    localparam int SZ = 5;

    logic                 clk      = 1'b0;
    logic                 rst      = 1'b1;
    logic                 en_FFT   = 1'b0;
    logic                 en_comp  = 1'b0;
    logic                 done_all = 1'b0;
    logic signed [BW-1:0] Re_in    = '0;
    logic signed [BW-1:0] Im_in    = '0;
    logic [15:0]          peak_bcd;
    logic [SZ-1:0]        peak_bin;
    logic [16:0]          peak_mag;
    logic                 peak_valid;
    logic                 busy;
    logic                 overflow;

    fft_peak_bcd #(.bit_width(BW), .N(NB), .SIZE(SZ)) dut (
        .clk        (clk),
        .rst        (rst),
        .en_FFT     (en_FFT),
        .en_comp    (en_comp),
        .Re_in      (Re_in),
        .Im_in      (Im_in),
        .done_all   (done_all),
        .peak_bcd   (peak_bcd),
        .peak_bin   (peak_bin),
        .peak_mag   (peak_mag),
        .peak_valid (peak_valid),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame model: magnitudes of the samples given in the current frame.
    int m_q[$];
    int exp_at   = -1;
    int pend_bin = 0;
    int pend_mag = 0;
    bit pend_ovf = 1'b0;
    int pub_bin  = 0;
    int pub_mag  = 0;
    bit chk_en   = 1'b0;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int sm();
        return int'($urandom_range(0, 80)) - 40;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                     name, act, act, expv, expv, $time);
        end
    endtask

    // Expected peak: first bin holding the largest magnitude among the first NB.
    task automatic close_frame();
        int best;
        int bi;
        best = -1;
        bi   = 0;
        for (int i = 0; i < m_q.size() && i < NB; i++) begin
            if (m_q[i] > best) begin
                best = m_q[i];
                bi   = i;
            end
        end
        if (best < 0) best = 0;
        pend_bin = bi;
        pend_mag = best;
        pend_ovf = (m_q.size() > NB);
        exp_at   = cyc + 3;
    endtask

    // Every cycle: pulse only when the model says so, outputs hold otherwise.
    always @(negedge clk) begin
        if (chk_en) begin
            if (cyc == exp_at) begin
                pub_bin = pend_bin;
                pub_mag = pend_mag;
            end
            check("peak_valid", 32'(peak_valid), 32'(cyc == exp_at));
            check("peak_bin", 32'(peak_bin), pub_bin);
            check("peak_mag", 32'(peak_mag), pub_mag);
            check("peak_bcd", 32'(peak_bcd), 32'(to_bcd(pub_bin)));
            if (cyc == exp_at) begin
                check("overflow_at_done", 32'(overflow), 32'(pend_ovf));
                check("busy_at_done", 32'(busy), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        en_FFT = 1'b1;
        m_q.delete();
        tick();
        en_FFT = 1'b0;
        check("busy_after_start", 32'(busy), 1);
    endtask

    task automatic put(input int re, input int im, input bit last);
        logic [7:0] r8;
        logic [7:0] i8;
        r8       = 8'(re);
        i8       = 8'(im);
        en_comp  = 1'b1;
        done_all = last;
        Re_in    = {r8, 26'($urandom)};
        Im_in    = {i8, 26'($urandom)};
        m_q.push_back(re * re + im * im);
        if (last) close_frame();
        tick();
        en_comp  = 1'b0;
        done_all = 1'b0;
    endtask

    task automatic finish_frame();
        done_all = 1'b1;
        close_frame();
        tick();
        done_all = 1'b0;
    endtask

    task automatic wait_valid();
        int i;
        i = 0;
        while (!peak_valid && i < 8) begin
            tick();
            i++;
        end
        check("valid_seen", 32'(peak_valid), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_bcd", 32'(peak_bcd), 0);
        check("rst_bin", 32'(peak_bin), 0);
        check("rst_mag", 32'(peak_mag), 0);
        check("rst_valid", 32'(peak_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf", 32'(overflow), 0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Samples and frame end while idle are ignored
        en_comp  = 1'b1;
        done_all = 1'b1;
        Re_in    = {8'h7F, 26'h0};
        tick();
        tick();
        en_comp  = 1'b0;
        done_all = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 0);

        // Single peak at bin 13, with idle gaps between samples
        start_frame();
        for (int i = 0; i < NB; i++) begin
            put((i == 13) ? 127 : 0, 0, 1'b0);
            if ($urandom_range(0, 3) == 0) tick();
        end
        finish_frame();
        wait_valid();
        check("b13_bcd", 32'(peak_bcd), 32'h0013);
        check("b13_bin", 32'(peak_bin), 13);
        check("b13_mag", 32'(peak_mag), 16129);
        tick();

        // Tie at bins 4 and 20, started the cycle after DONE
        start_frame();
        for (int i = 0; i < NB; i++) begin
            if (i == 4 || i == 20) put(-128, 0, 1'b0);
            else                   put(sm(), sm(), 1'b0);
        end
        finish_frame();
        wait_valid();
        check("tie_bin", 32'(peak_bin), 4);
        check("tie_mag", 32'(peak_mag), 16384);
        check("tie_bcd", 32'(peak_bcd), 32'h0004);
        tick();

        // Corner magnitude at bin 31
        start_frame();
        for (int i = 0; i < NB; i++) begin
            if (i == 31) put(-128, -128, 1'b0);
            else         put(sm(), sm(), 1'b0);
        end
        finish_frame();
        wait_valid();
        check("corner_mag", 32'(peak_mag), 32768);
        check("corner_bcd", 32'(peak_bcd), 32'h0031);
        check("corner_bin", 32'(peak_bin), 31);
        tick();

        // Overflow: 40 samples, largest at bin 35 must be ignored
        start_frame();
        for (int i = 0; i < 40; i++) begin
            if (i == 9)       put(100, 0, 1'b0);
            else if (i == 35) put(127, 127, 1'b0);
            else              put(sm(), sm(), 1'b0);
        end
        finish_frame();
        wait_valid();
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_bin", 32'(peak_bin), 9);
        check("ovf_mag", 32'(peak_mag), 10000);
        tick();

        // Restart mid-frame at sample 10, then restart from DRAIN
        start_frame();
        for (int i = 0; i < 10; i++) put((i == 3) ? -128 : sm(), (i == 3) ? -128 : sm(), 1'b0);
        start_frame();
        for (int i = 0; i < 5; i++) put(sm(), sm(), 1'b0);
        done_all = 1'b1;
        tick();
        done_all = 1'b0;
        start_frame();
        check("restart_ovf_clear", 32'(overflow), 0);
        for (int i = 0; i < NB; i++) begin
            if (i == 7) put(90, 60, 1'b0);
            else        put(sm(), sm(), 1'b0);
        end
        finish_frame();
        wait_valid();
        check("restart_bin", 32'(peak_bin), 7);
        check("restart_mag", 32'(peak_mag), 11700);
        tick();

        // Reset during DRAIN: no pulse, outputs cleared
        start_frame();
        for (int i = 0; i < NB; i++) put((i == 5) ? 110 : sm(), sm(), 1'b0);
        done_all = 1'b1;
        close_frame();
        tick();
        done_all = 1'b0;
        rst = 1'b1;
        tick();
        exp_at  = -1;
        pub_bin = 0;
        pub_mag = 0;
        rst     = 1'b0;
        check("drain_rst_bin", 32'(peak_bin), 0);
        check("drain_rst_mag", 32'(peak_mag), 0);
        check("drain_rst_bcd", 32'(peak_bcd), 0);
        check("drain_rst_valid", 32'(peak_valid), 0);
        check("drain_rst_busy", 32'(busy), 0);
        for (int i = 0; i < 5; i++) tick();

        // Frame end coinciding with the peak sample at bin 31
        start_frame();
        for (int i = 0; i < NB - 1; i++) put(sm(), sm(), 1'b0);
        put(120, -120, 1'b1);
        wait_valid();
        check("last_bin", 32'(peak_bin), 31);
        check("last_mag", 32'(peak_mag), 28800);
        check("last_bcd", 32'(peak_bcd), 32'h0031);
        for (int i = 0; i < 4; i++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
